// File: rtl/lvt_wr_scheduler_if.sv
// Write-request handshake bundle: one producer feeding one scheduler input FIFO.
interface lvt_wr_scheduler_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) ();
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/lvt_wr_scheduler.sv
// Two-producer write scheduler in front of lvt_bram: per-lane FIFO plus registered write
// port, with same-address arbitration so both bram write ports never hit one address.
module lvt_wr_lane #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              iss,
  input  logic [ADDR_W-1:0] hz_addr,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              hz_hit
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]             wr_ptr, rd_ptr, cnt;
  logic [DEPTH-1:0][ADDR_W-1:0] mem_addr;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data;
  logic [DEPTH-1:0][IDX_W-1:0]  ent_off;
  logic [DEPTH-1:0]             ent_vld, ent_hit;

  assign cnt   = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

  assign head_addr = mem_addr[rd_ptr[IDX_W-1:0]];
  assign head_data = mem_data[rd_ptr[IDX_W-1:0]];

  // A slot is live when its distance from the read pointer is below the fill count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_off[i] = IDX_W'(i) - rd_ptr[IDX_W-1:0];
    assign ent_vld[i] = ({1'b0, ent_off[i]} < cnt);
    assign ent_hit[i] = ent_vld[i] && (mem_addr[i] == hz_addr);
  end

  assign hz_hit = (|ent_hit) || (wr_en && (wr_addr == hz_addr));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (iss)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage is left unreset; only live slots are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr[IDX_W-1:0]] <= in_addr;
      mem_data[wr_ptr[IDX_W-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= iss;
      if (iss) begin
        wr_addr <= head_addr;
        wr_data <= head_data;
      end
    end
  end
endmodule

module lvt_wr_scheduler #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  lvt_wr_scheduler_if.slave   in0,
  lvt_wr_scheduler_if.slave   in1,
  output logic                wr0_en,
  output logic [ADDR_W-1:0]   wr0_addr,
  output logic [DATA_W-1:0]   wr0_data,
  output logic                wr1_en,
  output logic [ADDR_W-1:0]   wr1_addr,
  output logic [DATA_W-1:0]   wr1_data,
  input  logic [ADDR_W-1:0]   hz_addr,
  output logic                hz_pending,
  output logic                idle,
  output logic [15:0]         coll_cnt
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]             push, iss, empty, full, wr_en, hz_hit, hv;
  logic [NUM_LANES-1:0][ADDR_W-1:0] in_addr, head_addr, wr_addr;
  logic [NUM_LANES-1:0][DATA_W-1:0] in_data, head_data, wr_data;
  logic                             pri, coll;

  assign in0.ready = rst && !full[0];
  assign in1.ready = rst && !full[1];
  assign push      = {in1.valid && in1.ready, in0.valid && in0.ready};
  assign in_addr   = {in1.addr, in0.addr};
  assign in_data   = {in1.data, in0.data};

  // On a same-address pair only the pri-selected lane issues; the other retries next cycle.
  assign hv     = ~empty;
  assign coll   = hv[0] && hv[1] && (head_addr[0] == head_addr[1]);
  assign iss[0] = hv[0] && (!coll || !pri);
  assign iss[1] = hv[1] && (!coll ||  pri);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lvt_wr_lane #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .push      (push[g]),
      .in_addr   (in_addr[g]),
      .in_data   (in_data[g]),
      .iss       (iss[g]),
      .hz_addr   (hz_addr),
      .empty     (empty[g]),
      .full      (full[g]),
      .head_addr (head_addr[g]),
      .head_data (head_data[g]),
      .wr_en     (wr_en[g]),
      .wr_addr   (wr_addr[g]),
      .wr_data   (wr_data[g]),
      .hz_hit    (hz_hit[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pri      <= 1'b0;
      coll_cnt <= '0;
    end else if (coll) begin
      pri <= ~pri;
      if (coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
    end
  end

  assign wr0_en   = wr_en[0];
  assign wr0_addr = wr_addr[0];
  assign wr0_data = wr_data[0];
  assign wr1_en   = wr_en[1];
  assign wr1_addr = wr_addr[1];
  assign wr1_data = wr_data[1];

  assign hz_pending = |hz_hit;
  assign idle       = (&empty) && !(|wr_en);
endmodule

// File: tb/tb_lvt_wr_scheduler.sv
// Directed bench for lvt_wr_scheduler: main instance at DEPTH 4, small instance at DEPTH 2.
module tb_lvt_wr_scheduler;
  localparam int AW = 7;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lvt_wr_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) i0 ();
  lvt_wr_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) i1 ();
  lvt_wr_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) j0 ();
  lvt_wr_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) j1 ();

  logic          wr0_en, wr1_en, hz_pending, idle;
  logic [AW-1:0] wr0_addr, wr1_addr, hz_addr;
  logic [DW-1:0] wr0_data, wr1_data;
  logic [15:0]   coll_cnt;

  logic          d2_wr0_en, d2_wr1_en, d2_hz_pending, d2_idle;
  logic [AW-1:0] d2_wr0_addr, d2_wr1_addr, d2_hz_addr;
  logic [DW-1:0] d2_wr0_data, d2_wr1_data;
  logic [15:0]   d2_coll_cnt;

  lvt_wr_scheduler #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in0(i0), .in1(i1),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .hz_addr(hz_addr), .hz_pending(hz_pending), .idle(idle), .coll_cnt(coll_cnt)
  );

  lvt_wr_scheduler #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(2)) dut_d2 (
    .clk(clk), .rst(rst), .in0(j0), .in1(j1),
    .wr0_en(d2_wr0_en), .wr0_addr(d2_wr0_addr), .wr0_data(d2_wr0_data),
    .wr1_en(d2_wr1_en), .wr1_addr(d2_wr1_addr), .wr1_data(d2_wr1_data),
    .hz_addr(d2_hz_addr), .hz_pending(d2_hz_pending), .idle(d2_idle), .coll_cnt(d2_coll_cnt)
  );

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic mon_en = 1'b0;
  logic [AW+DW-1:0] q0[$];
  logic [AW+DW-1:0] q1[$];

  always @(negedge clk) begin
    if (mon_en && wr0_en) q0.push_back({wr0_addr, wr0_data});
    if (mon_en && wr1_en) q1.push_back({wr1_addr, wr1_data});
    if (wr0_en && wr1_en) chk("no_same_addr", 32'(wr0_addr != wr1_addr), 32'd1);
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a0, a1;
    i0.valid = 0; i0.addr = '0; i0.data = '0;
    i1.valid = 0; i1.addr = '0; i1.data = '0;
    j0.valid = 0; j0.addr = '0; j0.data = '0;
    j1.valid = 0; j1.addr = '0; j1.data = '0;
    hz_addr = '0; d2_hz_addr = '0;

    // reset state
    #2;
    chk("rst_wr0_en",   32'(wr0_en), 0);
    chk("rst_wr1_en",   32'(wr1_en), 0);
    chk("rst_wr0_addr", 32'(wr0_addr), 0);
    chk("rst_wr1_data", wr1_data, 0);
    chk("rst_coll",     32'(coll_cnt), 0);
    chk("rst_rdy0",     32'(i0.ready), 0);
    chk("rst_rdy1",     32'(i1.ready), 0);
    chk("rst_idle",     32'(idle), 1);
    chk("rst_hz",       32'(hz_pending), 0);
    step; step;
    #3 rst = 1'b1;
    #1;
    chk("rel_rdy0", 32'(i0.ready), 1);
    chk("rel_rdy1", 32'(i1.ready), 1);

    // single write
    i0.valid = 1; i0.addr = 7'd10; i0.data = 32'd5;
    step;
    i0.valid = 0;
    chk("single_lat",  32'(wr0_en), 0);
    chk("single_busy", 32'(idle), 0);
    step;
    chk("single_en",   32'(wr0_en), 1);
    chk("single_addr", 32'(wr0_addr), 10);
    chk("single_data", wr0_data, 5);
    chk("single_en1",  32'(wr1_en), 0);
    step;
    chk("single_off",  32'(wr0_en), 0);
    chk("single_hold", 32'(wr0_addr), 10);
    chk("single_idle", 32'(idle), 1);

    // parallel writes
    i0.valid = 1; i0.addr = 7'd30; i0.data = 32'd15;
    i1.valid = 1; i1.addr = 7'd40; i1.data = 32'd20;
    step;
    i0.valid = 0; i1.valid = 0;
    step;
    chk("par_en0",   32'(wr0_en), 1);
    chk("par_en1",   32'(wr1_en), 1);
    chk("par_addr0", 32'(wr0_addr), 30);
    chk("par_addr1", 32'(wr1_addr), 40);
    chk("par_data0", wr0_data, 15);
    chk("par_data1", wr1_data, 20);
    chk("par_coll",  32'(coll_cnt), 0);
    step;

    // collision, port 0 first
    i0.valid = 1; i0.addr = 7'd50; i0.data = 32'd25;
    i1.valid = 1; i1.addr = 7'd50; i1.data = 32'd30;
    step;
    i0.valid = 0; i1.valid = 0;
    step;
    chk("colA_en0",  32'(wr0_en), 1);
    chk("colA_data", wr0_data, 25);
    chk("colA_en1",  32'(wr1_en), 0);
    step;
    chk("colB_en0",  32'(wr0_en), 0);
    chk("colB_en1",  32'(wr1_en), 1);
    chk("colB_addr", 32'(wr1_addr), 50);
    chk("colB_data", wr1_data, 30);
    chk("colB_cnt",  32'(coll_cnt), 1);
    step;

    // second collision, port 1 first
    i0.valid = 1; i0.addr = 7'd60; i0.data = 32'd1;
    i1.valid = 1; i1.addr = 7'd60; i1.data = 32'd2;
    step;
    i0.valid = 0; i1.valid = 0;
    step;
    chk("col2A_en0",  32'(wr0_en), 0);
    chk("col2A_en1",  32'(wr1_en), 1);
    chk("col2A_data", wr1_data, 2);
    chk("col2A_cnt",  32'(coll_cnt), 2);
    step;
    chk("col2B_en0",  32'(wr0_en), 1);
    chk("col2B_data", wr0_data, 1);
    step;

    // streamed writes on both producers with handshake, ordering and no loss
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i0.valid = 1; i0.addr = AW'(17 + i); i0.data = DW'(256 + i);
      i1.valid = 1; i1.addr = AW'(17 + i); i1.data = DW'(512 + i);
      for (int t = 0; t < 20 && (i0.valid || i1.valid); t++) begin
        a0 = i0.valid && i0.ready;
        a1 = i1.valid && i1.ready;
        step;
        if (a0) i0.valid = 0;
        if (a1) i1.valid = 0;
      end
      chk("bp_accept", 32'({i0.valid, i1.valid}), 0);
      i0.valid = 0; i1.valid = 0;
    end
    for (int t = 0; t < 20 && !idle; t++) step;
    chk("bp_idle", 32'(idle), 1);
    mon_en = 1'b0;
    chk("bp_n0", 32'(q0.size()), 5);
    chk("bp_n1", 32'(q1.size()), 5);
    for (int k = 0; k < 5 && k < q0.size(); k++) begin
      chk("bp_addr0", 32'(q0[k][AW+DW-1:DW]), 32'(17 + k));
      chk("bp_data0", q0[k][DW-1:0], 32'(256 + k));
    end
    for (int k = 0; k < 5 && k < q1.size(); k++)
      chk("bp_data1", q1[k][DW-1:0], 32'(512 + k));
    chk("bp_coll", 32'(coll_cnt), 3);

    // hazard query
    hz_addr = 7'd70;
    #1 chk("hz_before", 32'(hz_pending), 0);
    i0.valid = 1; i0.addr = 7'd70; i0.data = 32'd35;
    step;
    i0.valid = 0;
    chk("hz_queued", 32'(hz_pending), 1);
    hz_addr = 7'd95;
    #1 chk("hz_other_q", 32'(hz_pending), 0);
    hz_addr = 7'd70;
    step;
    chk("hz_issue_en", 32'(wr0_en), 1);
    chk("hz_issue",    32'(hz_pending), 1);
    hz_addr = 7'd95;
    #1 chk("hz_other_i", 32'(hz_pending), 0);
    hz_addr = 7'd70;
    step;
    chk("hz_done", 32'(hz_pending), 0);

    // asynchronous reset with port 1 busy
    i1.valid = 1; i1.addr = 7'h21; i1.data = 32'hA1;
    step;
    i1.addr = 7'h22; i1.data = 32'hA2;
    step;
    i1.addr = 7'h23; i1.data = 32'hA3;
    step;
    i1.valid = 0;
    chk("ar_busy_en",   32'(wr1_en), 1);
    chk("ar_busy_addr", 32'(wr1_addr), 32'h22);
    #3 rst = 1'b0;
    #1;
    chk("ar_en",   32'(wr1_en), 0);
    chk("ar_addr", 32'(wr1_addr), 0);
    chk("ar_rdy",  32'(i1.ready), 0);
    chk("ar_idle", 32'(idle), 1);
    #2 rst = 1'b1;
    hz_addr = 7'h23;
    for (int t = 0; t < 3; t++) begin
      step;
      chk("ar_quiet", 32'({wr0_en, wr1_en}), 0);
      chk("ar_idle2", 32'(idle), 1);
    end
    chk("ar_rdy2", 32'(i1.ready), 1);
    chk("ar_hz",   32'(hz_pending), 0);

    // DEPTH 2 instance: full FIFO backpressure
    j0.valid = 1; j0.addr = 7'd5; j0.data = 32'h50;
    j1.valid = 1; j1.addr = 7'd5; j1.data = 32'h51;
    step;
    j0.valid = 0; j1.valid = 0;
    step;
    chk("d2_warm0", 32'(d2_wr0_en), 1);
    step;
    chk("d2_warm1", 32'(d2_wr1_en), 1);
    j0.valid = 1; j0.addr = 7'd6; j0.data = 32'h60;
    j1.valid = 1; j1.addr = 7'd6; j1.data = 32'h61;
    step;
    j1.valid = 0;
    j0.addr = 7'd7; j0.data = 32'h70;
    chk("d2_rdy_1", 32'(j0.ready), 1);
    step;
    chk("d2_full_rdy", 32'(j0.ready), 0);
    chk("d2_p1_first", 32'(d2_wr1_en), 1);
    chk("d2_p0_held",  32'(d2_wr0_en), 0);
    j0.addr = 7'd8; j0.data = 32'h80;
    step;
    chk("d2_pop_en",   32'(d2_wr0_en), 1);
    chk("d2_pop_addr", 32'(d2_wr0_addr), 6);
    chk("d2_rdy_back", 32'(j0.ready), 1);
    step;
    j0.valid = 0;
    chk("d2_b_addr", 32'(d2_wr0_addr), 7);
    step;
    chk("d2_c_addr", 32'(d2_wr0_addr), 8);
    chk("d2_c_data", d2_wr0_data, 32'h80);
    step;
    chk("d2_idle", 32'(d2_idle), 1);
    chk("d2_coll", 32'(d2_coll_cnt), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
